aes_sbox_sched: RTL and testbench

Shares one 4-lane bank of AES S-boxes (four `aes_sbox` instances, 32 bits per cycle) between two requesters. The key expansion requester submits one 32-bit word. The block (cipher-round SubBytes) requester submits a 128-bit state, processed as four 32-bit beats. The block sits between the key memory/round-key logic and the encipher datapath and replaces their private S-box copies.

---
 rtl/aes_sbox_sched.sv | 167 ++++++++++++++++
 tb/tb_aes_sbox_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_sched.sv
// ============================================================================
// Module   : aes_sbox_sched
// Purpose  : One 4-lane AES S-box bank shared between key expansion and
//            block SubBytes requesters; blocks run as four MSB-first beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    assign dout = affine(gf_inv(din));
endmodule

module aes_sbox_sched #(
    parameter int KEY_HAS_PRIORITY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_req,
    input  logic [31:0]  key_word,
    output logic         key_ack,
    output logic [31:0]  key_result,
    input  logic         blk_req,
    input  logic [127:0] blk_data,
    output logic         blk_ack,
    output logic [127:0] blk_result,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        BLK  = 2'd2
    } state_t;

    localparam bit c_key_pri = (KEY_HAS_PRIORITY != 0);

    state_t      r_state;
    logic [1:0]  r_beat;
    logic        r_last_key;
    logic        r_in_prog;

    logic        w_key_elig;
    logic        w_blk_elig;
    logic [31:0] w_blk_word;
    logic [31:0] w_lane_in;
    logic [31:0] w_lane_out;

    // A requester still seeing its own ack must not be granted again.
    assign w_key_elig = key_req & ~key_ack;
    assign w_blk_elig = blk_req & ~blk_ack;

    always_comb begin
        w_blk_word = blk_data[127:96];
        case (r_beat)
            2'd0:    w_blk_word = blk_data[127:96];
            2'd1:    w_blk_word = blk_data[95:64];
            2'd2:    w_blk_word = blk_data[63:32];
            default: w_blk_word = blk_data[31:0];
        endcase
    end

    assign w_lane_in = (r_state == KEY) ? key_word : w_blk_word;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            aes_sbox u_sbox (
                .din  (w_lane_in[8*i +: 8]),
                .dout (w_lane_out[8*i +: 8])
            );
        end
    endgenerate

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_beat     <= 2'd0;
            r_last_key <= 1'b0;
            r_in_prog  <= 1'b0;
            key_ack    <= 1'b0;
            blk_ack    <= 1'b0;
            key_result <= 32'h0;
            blk_result <= 128'h0;
        end else begin
            key_ack <= 1'b0;
            blk_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_key_elig && (!w_blk_elig || c_key_pri || !r_last_key)) begin
                        r_state <= KEY;
                    end else if (w_blk_elig) begin
                        r_state   <= BLK;
                        r_beat    <= 2'd0;
                        r_in_prog <= 1'b1;
                    end
                end
                KEY: begin
                    key_result <= w_lane_out;
                    key_ack    <= 1'b1;
                    r_last_key <= 1'b1;
                    if (r_in_prog) begin
                        r_state <= BLK;
                    end else if (w_blk_elig) begin
                        r_state   <= BLK;
                        r_beat    <= 2'd0;
                        r_in_prog <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BLK: begin
                    case (r_beat)
                        2'd0:    blk_result[127:96] <= w_lane_out;
                        2'd1:    blk_result[95:64]  <= w_lane_out;
                        2'd2:    blk_result[63:32]  <= w_lane_out;
                        default: blk_result[31:0]   <= w_lane_out;
                    endcase
                    if (r_beat == 2'd3) begin
                        blk_ack    <= 1'b1;
                        r_last_key <= 1'b0;
                        r_in_prog  <= 1'b0;
                        r_state    <= (c_key_pri && w_key_elig) ? KEY : IDLE;
                    end else begin
                        r_beat  <= r_beat + 2'd1;
                        r_state <= (c_key_pri && w_key_elig) ? KEY : BLK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_aes_sbox_sched.sv
// ============================================================================
// Module   : tb_aes_sbox_sched
// Purpose  : Bench for aes_sbox_sched: one instance per priority mode, with
//            cycle-scheduled expectations compared against the DUTs each cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_sbox_sched;
    localparam int MAXC = 512;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   key_req;
    logic [31:0]  key_word   [2];
    logic [1:0]   key_ack;
    logic [31:0]  key_result [2];
    logic [1:0]   blk_req;
    logic [127:0] blk_data   [2];
    logic [1:0]   blk_ack;
    logic [127:0] blk_result [2];
    logic [1:0]   busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit           e_kack [2][MAXC];
    bit           e_back [2][MAXC];
    bit           e_busy [2][MAXC];
    bit           kupd   [2][MAXC];
    bit           bupd   [2][MAXC];
    logic [31:0]  kval   [2][MAXC];
    logic [127:0] bval   [2][MAXC];
    logic [31:0]  mk     [2];
    logic [127:0] mb     [2];

    aes_sbox_sched #(.KEY_HAS_PRIORITY(1)) dut (
        .clk(clk), .reset(reset),
        .key_req(key_req[0]), .key_word(key_word[0]),
        .key_ack(key_ack[0]), .key_result(key_result[0]),
        .blk_req(blk_req[0]), .blk_data(blk_data[0]),
        .blk_ack(blk_ack[0]), .blk_result(blk_result[0]),
        .busy(busy[0])
    );

    aes_sbox_sched #(.KEY_HAS_PRIORITY(0)) dut_alt (
        .clk(clk), .reset(reset),
        .key_req(key_req[1]), .key_word(key_word[1]),
        .key_ack(key_ack[1]), .key_result(key_result[1]),
        .blk_req(blk_req[1]), .blk_data(blk_data[1]),
        .blk_ack(blk_ack[1]), .blk_result(blk_result[1]),
        .busy(busy[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference S-box: carry-less product reduced mod x^8+x^4+x^3+x+1,
    // inverse by exhaustive search, then the bitwise affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) r = 8'(y);
        return r;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] v;
        logic [7:0] c;
        logic [7:0] b;
        v = ginv(x);
        c = 8'h63;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            b[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
        return b;
    endfunction

    function automatic logic [31:0] sbw(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sb(w[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] sbb(input logic [127:0] w);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sb(w[8*k +: 8]);
        return r;
    endfunction

    task automatic check(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %h want %h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_busy(input int d, input int a, input int b);
        for (int c = a; c <= b; c++) e_busy[d][c] = 1'b1;
    endtask

    task automatic exp_key(input int d, input int c, input logic [31:0] w);
        e_kack[d][c] = 1'b1;
        kupd[d][c]   = 1'b1;
        kval[d][c]   = sbw(w);
    endtask

    task automatic exp_blk(input int d, input int c, input logic [127:0] x);
        e_back[d][c] = 1'b1;
        bupd[d][c]   = 1'b1;
        bval[d][c]   = sbb(x);
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    mk[d] = 32'h0;
                    mb[d] = 128'h0;
                end else begin
                    if (kupd[d][cyc]) mk[d] = kval[d][cyc];
                    if (bupd[d][cyc]) mb[d] = bval[d][cyc];
                end
                check("key_ack", d, 128'(key_ack[d]), 128'(e_kack[d][cyc] && !reset));
                check("blk_ack", d, 128'(blk_ack[d]), 128'(e_back[d][cyc] && !reset));
                check("busy", d, 128'(busy[d]), 128'(e_busy[d][cyc] && !reset));
                check("key_result", d, 128'(key_result[d]), 128'(mk[d]));
                if (reset || e_back[d][cyc])
                    check("blk_result", d, blk_result[d], mb[d]);
            end
        end
    end

    localparam logic [127:0] c_blk_a = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_blk_b = 128'h0123456789abcdeffedcba9876543210;

    initial begin
        int n;
        logic [31:0]  kw [3];
        logic [127:0] bd [3];
        for (int d = 0; d < 2; d++) begin
            mk[d] = 32'h0;
            mb[d] = 128'h0;
            key_word[d] = 32'h0;
            blk_data[d] = 128'h0;
        end
        key_req = 2'b00;
        blk_req = 2'b00;
        reset   = 1'b0;
        #1 reset = 1'b1;

        check("pin_sbw_key", 0, 128'(sbw(32'h00010203)), 128'h637c777b);
        check("pin_sbb_blk", 0, sbb(c_blk_a), 128'h638293c31bfc33f5c4eeacea4bc12816);
        check("pin_sb_52", 0, 128'(sb(8'h52)), 128'h00);
        check("pin_sb_ff", 0, 128'(sb(8'hff)), 128'h16);

        tick(3);
        reset = 1'b0;
        tick(2);

        // Key alone
        n = cyc;
        key_word[0] = 32'h00010203;
        key_req[0]  = 1'b1;
        exp_busy(0, n + 1, n + 1);
        exp_key(0, n + 2, 32'h00010203);
        tick(2);
        key_req[0] = 1'b0;
        tick(2);

        // Block alone
        n = cyc;
        blk_data[0] = c_blk_a;
        blk_req[0]  = 1'b1;
        exp_busy(0, n + 1, n + 4);
        exp_blk(0, n + 5, c_blk_a);
        tick(5);
        blk_req[0] = 1'b0;
        tick(2);

        // Simultaneous requests, key first
        n = cyc;
        key_word[0] = 32'h52525252;
        key_req[0]  = 1'b1;
        blk_req[0]  = 1'b1;
        exp_busy(0, n + 1, n + 5);
        exp_key(0, n + 2, 32'h52525252);
        exp_blk(0, n + 6, c_blk_a);
        tick(2);
        key_req[0] = 1'b0;
        tick(4);
        blk_req[0] = 1'b0;
        tick(2);

        // Preemption between beat 1 and beat 2
        n = cyc;
        blk_data[0] = c_blk_b;
        blk_req[0]  = 1'b1;
        exp_busy(0, n + 1, n + 5);
        exp_key(0, n + 4, 32'hffffffff);
        exp_blk(0, n + 6, c_blk_b);
        tick(2);
        key_word[0] = 32'hffffffff;
        key_req[0]  = 1'b1;
        tick(2);
        key_req[0] = 1'b0;
        tick(2);
        blk_req[0] = 1'b0;
        tick(2);

        // Reset during beat 2, block request held through it
        n = cyc;
        blk_data[0] = c_blk_a;
        blk_req[0]  = 1'b1;
        exp_busy(0, n + 1, n + 2);
        tick(3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        n = cyc;
        exp_busy(0, n + 1, n + 4);
        exp_blk(0, n + 5, c_blk_a);
        tick(5);
        blk_req[0] = 1'b0;
        tick(2);

        // Alternating priority with both requests held continuously
        kw[0] = 32'h00010203; kw[1] = 32'h52525252; kw[2] = 32'hffffffff;
        bd[0] = c_blk_a;      bd[1] = c_blk_b;      bd[2] = ~c_blk_a;
        n = cyc;
        for (int r = 0; r < 3; r++) begin
            exp_busy(1, n + 1 + 6*r, n + 5 + 6*r);
            exp_key(1, n + 2 + 6*r, kw[r]);
            exp_blk(1, n + 6 + 6*r, bd[r]);
        end
        key_word[1] = kw[0];
        blk_data[1] = bd[0];
        key_req[1]  = 1'b1;
        blk_req[1]  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick(2);
            if (r < 2) key_word[1] = kw[r+1];
            else       key_req[1]  = 1'b0;
            tick(4);
            if (r < 2) blk_data[1] = bd[r+1];
            else       blk_req[1]  = 1'b0;
        end
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
